// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges ALU and load results into one register-file write port,
// each source buffered in its own FIFO, loads favoured but ALU never starved.
module wb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wp_q, rp_q;
    logic [CW-1:0] cnt_q;
    assign head_o  = mem_q[rp_q];
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == CW'(DEPTH);
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wp_q] <= din_i;
    end
    // power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wp_q <= wp_q + 1'b1;
            if (pop_i) rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end
endmodule

module writeback_arbiter #(
    parameter int N     = 32,
    parameter int Bits  = 64,
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    input  logic [$clog2(N)-1:0] alu_rd,
    input  logic [Bits-1:0]      alu_data,
    output logic                 alu_ready,
    input  logic                 mem_valid,
    input  logic [$clog2(N)-1:0] mem_rd,
    input  logic [Bits-1:0]      mem_data,
    output logic                 mem_ready,
    output logic                 wr_en,
    output logic [$clog2(N)-1:0] ptr_wr,
    output logic [Bits-1:0]      data_wr,
    output logic                 busy
);
    localparam int RW = $clog2(N);
    logic              init_q, wr_en_q;
    logic [1:0]        skip_q, skip_d;
    logic [RW-1:0]     ptr_q;
    logic [Bits-1:0]   data_q;
    logic              alu_empty, alu_full, mem_empty, mem_full;
    logic              alu_push, mem_push, alu_win, mem_win;
    logic [RW+Bits-1:0] alu_head, mem_head, win_head;
    // init_q keeps both sources stalled until the first edge after reset release
    assign alu_ready = init_q & ~alu_full;
    assign mem_ready = init_q & ~mem_full;
    assign alu_push  = alu_valid & alu_ready & (alu_rd != '0);
    assign mem_push  = mem_valid & mem_ready & (mem_rd != '0);
    assign alu_win   = ~alu_empty & (mem_empty | skip_q == 2'd2);
    assign mem_win   = ~mem_empty & ~alu_win;
    assign skip_d    = (alu_win | alu_empty) ? 2'd0 : skip_q + 2'd1;
    assign win_head  = alu_win ? alu_head : mem_head;
    assign wr_en     = wr_en_q;
    assign ptr_wr    = ptr_q;
    assign data_wr   = data_q;
    assign busy      = ~alu_empty | ~mem_empty | wr_en_q;
    wb_fifo #(.W(RW + Bits), .DEPTH(DEPTH)) u_alu_fifo (
        .clk(clk), .rst(rst), .push_i(alu_push), .din_i({alu_rd, alu_data}),
        .pop_i(alu_win), .head_o(alu_head), .empty_o(alu_empty), .full_o(alu_full)
    );
    wb_fifo #(.W(RW + Bits), .DEPTH(DEPTH)) u_mem_fifo (
        .clk(clk), .rst(rst), .push_i(mem_push), .din_i({mem_rd, mem_data}),
        .pop_i(mem_win), .head_o(mem_head), .empty_o(mem_empty), .full_o(mem_full)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_q  <= 1'b0;
            skip_q  <= 2'd0;
            wr_en_q <= 1'b0;
            ptr_q   <= '0;
            data_q  <= '0;
        end else begin
            init_q  <= 1'b1;
            skip_q  <= skip_d;
            wr_en_q <= alu_win | mem_win;
            if (alu_win | mem_win) {ptr_q, data_q} <= win_head;
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: queue-based reference model feeds a scoreboard that a
// negedge monitor drains cycle-exactly against the register-file write port.
module tb_writeback_arbiter;
    localparam int DEPTH = 2;
    logic        clk = 1'b0, rst = 1'b0;
    logic        alu_valid = 1'b0, mem_valid = 1'b0;
    logic [4:0]  alu_rd = '0, mem_rd = '0;
    logic [63:0] alu_data = '0, mem_data = '0;
    logic        alu_ready, mem_ready, wr_en, busy;
    logic [4:0]  ptr_wr;
    logic [63:0] data_wr;

    writeback_arbiter #(.N(32), .Bits(64), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .wr_en(wr_en), .ptr_wr(ptr_wr), .data_wr(data_wr), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [4:0] rd; logic [63:0] d; } ent_t;
    typedef struct { int c; logic [4:0] rd; logic [63:0] d; } exp_t;
    ent_t aq[$], mq[$];
    exp_t sb[$];
    int   skip = 0, cyc = 0, checks = 0, errors = 0;
    bit   init = 1'b0, last_win = 1'b0;
    logic [4:0]  last_ptr = '0;
    logic [63:0] last_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic flush_model();
        aq.delete(); mq.delete(); sb.delete();
        skip = 0; init = 1'b0; last_win = 1'b0;
        last_ptr = '0; last_data = '0;
    endtask

    // One clock: check visible state, drive inputs, predict the next edge.
    task automatic cycle(input bit av, input logic [4:0] ar, input logic [63:0] ad,
                         input bit mv, input logic [4:0] mr, input logic [63:0] md,
                         output bit aa, output bit ma);
        bit ra, rm;
        ent_t e;
        @(posedge clk); #1;
        rst = 1'b1;
        ra = init && aq.size() < DEPTH;
        rm = init && mq.size() < DEPTH;
        chk("alu_ready", alu_ready, ra);
        chk("mem_ready", mem_ready, rm);
        chk("busy", busy, aq.size() != 0 || mq.size() != 0 || last_win);
        alu_valid = av; alu_rd = ar; alu_data = ad;
        mem_valid = mv; mem_rd = mr; mem_data = md;
        if (aq.size() != 0 && (mq.size() == 0 || skip == 2)) begin
            e = aq.pop_front();
            skip = 0;
            sb.push_back('{cyc + 1, e.rd, e.d});
            last_win = 1'b1;
        end else if (mq.size() != 0) begin
            e = mq.pop_front();
            skip = (aq.size() != 0) ? skip + 1 : 0;
            sb.push_back('{cyc + 1, e.rd, e.d});
            last_win = 1'b1;
        end else begin
            skip = 0;
            last_win = 1'b0;
        end
        aa = av && ra;
        ma = mv && rm;
        if (aa && ar != 0) aq.push_back('{ar, ad});
        if (ma && mr != 0) mq.push_back('{mr, md});
        init = 1'b1;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (wr_en) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL spurious_wr: got ptr %0h data %0h expected no write", ptr_wr, data_wr);
                    end else begin
                        x = sb.pop_front();
                        chk("wr_cycle", 64'(cyc), 64'(x.c));
                        chk("ptr_wr", ptr_wr, x.rd);
                        chk("data_wr", data_wr, x.d);
                        last_ptr = x.rd; last_data = x.d;
                    end
                end else begin
                    if (sb.size() != 0 && sb[0].c == cyc) chk("wr_en", wr_en, 1);
                    chk("ptr_hold", ptr_wr, last_ptr);
                    chk("data_hold", data_wr, last_data);
                end
            end
        end
    end

    task automatic reset_midway();
        @(posedge clk); #1;
        rst = 1'b0;
        flush_model();
        #1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_alu_ready", alu_ready, 0);
        chk("rst_mem_ready", mem_ready, 0);
        chk("rst_busy", busy, 0);
        alu_valid = 1'b1; alu_rd = 5'd7; mem_valid = 1'b1; mem_rd = 5'd8;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_alu_ready", alu_ready, 0);
        chk("rst_hold_ptr", ptr_wr, 0);
        chk("rst_hold_data", data_wr, 0);
    endtask

    initial begin : stim
        bit aa, ma;
        logic [4:0] ar, mr;
        #3;
        chk("init_wr_en", wr_en, 0);
        chk("init_ptr", ptr_wr, 0);
        chk("init_data", data_wr, 0);
        chk("init_busy", busy, 0);
        chk("init_alu_ready", alu_ready, 0);
        chk("init_mem_ready", mem_ready, 0);
        alu_valid = 1'b1; alu_rd = 5'd3; mem_valid = 1'b1; mem_rd = 5'd4;
        repeat (2) @(posedge clk);
        alu_valid = 1'b0; mem_valid = 1'b0;
        // release, then single ALU write and an x0 load
        cycle(0, 0, 0, 0, 0, 0, aa, ma);
        cycle(1, 5'd5, 64'h1234, 0, 0, 0, aa, ma);
        repeat (4) cycle(0, 0, 0, 0, 0, 0, aa, ma);
        cycle(0, 0, 0, 1, 5'd0, 64'hFFFF, aa, ma);
        repeat (3) cycle(0, 0, 0, 0, 0, 0, aa, ma);
        // contention: both sources push continuously
        ar = 5'd1; mr = 5'd10;
        repeat (40) begin
            cycle(1, ar, {$urandom, $urandom}, 1, mr, {$urandom, $urandom}, aa, ma);
            if (aa) ar = (ar == 5'd9) ? 5'd1 : ar + 5'd1;
            if (ma) mr = (mr == 5'd31) ? 5'd10 : mr + 5'd1;
        end
        reset_midway();
        cycle(1, 5'd9, 64'hA5A5, 0, 0, 0, aa, ma);
        cycle(1, 5'd9, 64'hBEEF, 0, 0, 0, aa, ma);
        repeat (4) cycle(0, 0, 0, 0, 0, 0, aa, ma);
        // randomized traffic including x0 targets
        repeat (1500) begin
            cycle($urandom_range(0, 99) < 60, 5'($urandom_range(0, 31)), {$urandom, $urandom},
                  $urandom_range(0, 99) < 60, 5'($urandom_range(0, 31)), {$urandom, $urandom}, aa, ma);
        end
        repeat (2) cycle(1, 5'd2, 64'h11, 1, 5'd3, 64'h22, aa, ma);
        reset_midway();
        repeat (10) cycle(0, 0, 0, 0, 0, 0, aa, ma);
        chk("sb_drained", 64'(sb.size()), 0);
        chk("final_busy", busy, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
